// File: rtl/basys3_seg_scan.sv
// basys3_seg_scan: time-multiplexed driver for the Basys3 4-digit common-anode
// seven-segment display. Scans digits round-robin with a per-slot guard band,
// PWM dimming and per-digit blanking. Writes land in a shadow register and
// are committed to the displayed (active) register only at frame boundaries.
//
// Write handshake: a write is accepted on any cycle where wr_en && wr_ready.
// wr_ready is low from the cycle after acceptance until the cycle after the
// frame boundary that commits the shadow; wr_en while wr_ready is low is
// ignored and leaves the shadow untouched.
module basys3_seg_scan #(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic [3:0]  wr_dp,
   input  logic [3:0]  blank_mask,
   input  logic [3:0]  brightness,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        wr_ready,
   output logic        frame_tick
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GUARD_V   = CW'(GUARD);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } wr_state_t;

   logic [CW-1:0] slot_cnt;
   logic [1:0]    digit;
   logic [3:0]    pwm_cnt;
   logic [15:0]   act_data;
   logic [3:0]    act_dp;
   logic [15:0]   sh_data;
   logic [3:0]    sh_dp;
   wr_state_t     state;
   wr_state_t     state_nxt;
   logic          capture;
   logic          commit;
   logic          slot_last;
   logic          boundary;
   logic [3:0]    cur_nib;
   logic          cur_dp;
   logic          cur_blank;
   logic          an_en;
   logic [3:0]    an_nxt;

   // Active-low hex glyphs, {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0: hex_to_seg = 7'b1000000;
         4'h1: hex_to_seg = 7'b1111001;
         4'h2: hex_to_seg = 7'b0100100;
         4'h3: hex_to_seg = 7'b0110000;
         4'h4: hex_to_seg = 7'b0011001;
         4'h5: hex_to_seg = 7'b0010010;
         4'h6: hex_to_seg = 7'b0000010;
         4'h7: hex_to_seg = 7'b1111000;
         4'h8: hex_to_seg = 7'b0000000;
         4'h9: hex_to_seg = 7'b0010000;
         4'hA: hex_to_seg = 7'b0001000;
         4'hB: hex_to_seg = 7'b0000011;
         4'hC: hex_to_seg = 7'b1000110;
         4'hD: hex_to_seg = 7'b0100001;
         4'hE: hex_to_seg = 7'b0000110;
         default: hex_to_seg = 7'b0001110;
      endcase
   endfunction

   assign slot_last = (slot_cnt == SLOT_LAST);
   assign boundary  = slot_last && (digit == 2'd3);

   // Slot, digit and PWM counters; digit wrap 3->0 marks the frame boundary.
   always_ff @(posedge clock) begin
      if (reset) begin
         slot_cnt <= '0;
         digit    <= 2'd0;
         pwm_cnt  <= 4'd0;
      end else begin
         if (slot_last) begin
            slot_cnt <= '0;
            digit    <= digit + 2'd1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
         pwm_cnt <= pwm_cnt + 4'd1;
      end
   end

   // Write handshake state register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Handshake next state: capture when idle, commit at the boundary when pending.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (wr_en) begin
               capture   = 1'b1;
               state_nxt = PEND;
            end
         end
         PEND: begin
            if (boundary) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shadow and active data registers; reset discards any pending shadow.
   always_ff @(posedge clock) begin
      if (reset) begin
         sh_data  <= 16'h0000;
         sh_dp    <= 4'h0;
         act_data <= 16'h0000;
         act_dp   <= 4'h0;
      end else begin
         if (capture) begin
            sh_data <= wr_data;
            sh_dp   <= wr_dp;
         end
         if (commit) begin
            act_data <= sh_data;
            act_dp   <= sh_dp;
         end
      end
   end

   // Select the current digit's nibble, decimal point and blank bit.
   always_comb begin
      cur_nib   = act_data[3:0];
      cur_dp    = act_dp[0];
      cur_blank = blank_mask[0];
      case (digit)
         2'd0: begin cur_nib = act_data[3:0];   cur_dp = act_dp[0]; cur_blank = blank_mask[0]; end
         2'd1: begin cur_nib = act_data[7:4];   cur_dp = act_dp[1]; cur_blank = blank_mask[1]; end
         2'd2: begin cur_nib = act_data[11:8];  cur_dp = act_dp[2]; cur_blank = blank_mask[2]; end
         default: begin cur_nib = act_data[15:12]; cur_dp = act_dp[3]; cur_blank = blank_mask[3]; end
      endcase
   end

   // Anode is on only past the guard band, inside the PWM window and unblanked.
   always_comb begin
      an_en  = (slot_cnt >= GUARD_V) && (pwm_cnt <= brightness) && !cur_blank;
      an_nxt = 4'b1111;
      if (an_en) an_nxt = ~(4'b0001 << digit);
   end

   // Registered pin drivers.
   always_ff @(posedge clock) begin
      if (reset) begin
         an         <= 4'b1111;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
         wr_ready   <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         an         <= an_nxt;
         seg        <= hex_to_seg(cur_nib);
         dp         <= ~cur_dp;
         wr_ready   <= (state_nxt == IDLE);
         frame_tick <= boundary;
      end
   end

endmodule

// File: tb/tb_basys3_seg_scan.sv
// Bench for basys3_seg_scan with REFRESH_DIV=8, GUARD=1. A cycle-indexed
// reference model derives slot/digit/pwm from the cycle count since reset and
// predicts every output cycle; directed sequences cover the corner cases.
module tb_basys3_seg_scan;

   localparam int RD    = 8;
   localparam int G     = 1;
   localparam int FRAME = 4 * RD;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [15:0] wr_data;
   logic [3:0]  wr_dp;
   logic [3:0]  blank_mask;
   logic [3:0]  brightness;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        wr_ready;
   logic        frame_tick;

   basys3_seg_scan #(.REFRESH_DIV(RD), .GUARD(G)) dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .wr_dp(wr_dp), .blank_mask(blank_mask), .brightness(brightness),
      .seg(seg), .dp(dp), .an(an), .wr_ready(wr_ready), .frame_tick(frame_tick)
   );

   // clock / reset
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] nib;
      logic [6:0] exp_seg;
   } dec_vec_t;
   dec_vec_t vecs[16];

   // reference model state
   int          k;
   logic [15:0] m_act, m_sh;
   logic [3:0]  m_act_dp, m_sh_dp;
   bit          m_pend;
   logic [13:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // One clock: drive inputs, predict the outputs after the edge, compare.
   task automatic step(input logic we, input logic [15:0] wd, input logic [3:0] wdp);
      int          slot, dig, pwm, kk;
      logic        bnd;
      logic [3:0]  e_an;
      logic [15:0] sh;
      logic [6:0]  e_seg;
      logic        e_dp;
      logic [13:0] got;
      wr_en   = we;
      wr_data = wd;
      wr_dp   = wdp;
      kk   = k;
      slot = k % RD;
      dig  = (k / RD) % 4;
      pwm  = k % 16;
      bnd  = ((k % FRAME) == FRAME - 1);
      e_an = 4'b1111;
      if (slot >= G && pwm <= int'(brightness) && !blank_mask[dig]) e_an = ~(4'b0001 << dig);
      sh    = m_act >> (4 * dig);
      e_seg = vecs[sh[3:0]].exp_seg;
      e_dp  = ~m_act_dp[dig];
      if (bnd && m_pend) begin
         m_act    = m_sh;
         m_act_dp = m_sh_dp;
         m_pend   = 1'b0;
      end else if (!m_pend && we) begin
         m_sh    = wd;
         m_sh_dp = wdp;
         m_pend  = 1'b1;
      end
      exp_q.push_back({e_an, e_seg, e_dp, ~m_pend, bnd});
      @(posedge clock);
      @(negedge clock);
      got = {an, seg, dp, wr_ready, frame_tick};
      check($sformatf("cycle%0d", kk), 32'(got), 32'(exp_q.pop_front()));
      k++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_en = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_out", 32'({an, seg, dp, wr_ready, frame_tick}),
            32'({4'b1111, 7'b1111111, 1'b1, 1'b1, 1'b0}));
      reset    = 1'b0;
      k        = 0;
      m_act    = 16'h0;
      m_sh     = 16'h0;
      m_act_dp = 4'h0;
      m_sh_dp  = 4'h0;
      m_pend   = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_ready(output int n, output int ticks);
      n = 0;
      ticks = 0;
      while (wr_ready !== 1'b1 && n < 80) begin
         step(1'b0, 16'h0, 4'h0);
         n++;
         if (frame_tick === 1'b1) ticks++;
      end
      if (wr_ready !== 1'b1) check("wait_ready_timeout", 32'(wr_ready), 32'd1);
   endtask

   initial begin
      int n, ticks, bad, lit, viol, kk;
      logic [6:0] dseg[4];
      logic       ddp[4];
      int         dlit[4];

      vecs[0]  = '{4'h0, 7'b1000000}; vecs[1]  = '{4'h1, 7'b1111001};
      vecs[2]  = '{4'h2, 7'b0100100}; vecs[3]  = '{4'h3, 7'b0110000};
      vecs[4]  = '{4'h4, 7'b0011001}; vecs[5]  = '{4'h5, 7'b0010010};
      vecs[6]  = '{4'h6, 7'b0000010}; vecs[7]  = '{4'h7, 7'b1111000};
      vecs[8]  = '{4'h8, 7'b0000000}; vecs[9]  = '{4'h9, 7'b0010000};
      vecs[10] = '{4'hA, 7'b0001000}; vecs[11] = '{4'hB, 7'b0000011};
      vecs[12] = '{4'hC, 7'b1000110}; vecs[13] = '{4'hD, 7'b0100001};
      vecs[14] = '{4'hE, 7'b0000110}; vecs[15] = '{4'hF, 7'b0001110};

      wr_data = 16'h0; wr_dp = 4'h0; blank_mask = 4'h0; brightness = 4'd15;

      // 1: reset and first anode
      do_reset();
      step(1'b0, 16'h0, 4'h0);
      check("an_c1", 32'(an), 32'(4'b1111));
      step(1'b0, 16'h0, 4'h0);
      check("an0_low_c2", 32'(an), 32'(4'b1110));
      check("seg_c2", 32'(seg), 32'(7'b1000000));

      // 2: write and commit
      step(1'b1, 16'h1A2F, 4'b0100);
      check("ready_low_after_wr", 32'(wr_ready), 32'd0);
      wait_ready(n, ticks);
      check("commit_tick", 32'(ticks), 32'd1);
      for (int d = 0; d < 4; d++) begin dlit[d] = 0; dseg[d] = 7'h7F; ddp[d] = 1'b1; end
      for (int i = 0; i < FRAME; i++) begin
         step(1'b0, 16'h0, 4'h0);
         for (int d = 0; d < 4; d++)
            if (an == ~(4'b0001 << d)) begin dlit[d]++; dseg[d] = seg; ddp[d] = dp; end
      end
      for (int d = 0; d < 4; d++) check($sformatf("lit_cnt_d%0d", d), 32'(dlit[d]), 32'd7);
      check("d0_seg", 32'(dseg[0]), 32'(7'b0001110));
      check("d1_seg", 32'(dseg[1]), 32'(7'b0100100));
      check("d2_seg", 32'(dseg[2]), 32'(7'b0001000));
      check("d2_dp",  32'(ddp[2]),  32'd0);
      check("d3_seg", 32'(dseg[3]), 32'(7'b1111001));
      check("d3_dp",  32'(ddp[3]),  32'd1);

      // 3: back-pressure
      step(1'b1, 16'h1111, 4'h0);
      step(1'b1, 16'h2222, 4'h0);
      wait_ready(n, ticks);
      bad = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step(1'b0, 16'h0, 4'h0);
         if (an != 4'b1111 && seg != 7'b1111001) bad++;
      end
      check("backpressure_glyph", 32'(bad), 32'd0);

      // 4: write exactly on the boundary cycle
      n = 0;
      while ((k % FRAME) != FRAME - 1 && n < 40) begin step(1'b0, 16'h0, 4'h0); n++; end
      step(1'b1, 16'h4321, 4'h0);
      check("bnd_tick", 32'(frame_tick), 32'd1);
      check("bnd_ready_low", 32'(wr_ready), 32'd0);
      wait_ready(n, ticks);
      check("bnd_commit_delay", 32'(n), 32'd32);

      // 5: blanking and PWM
      blank_mask = 4'b1010;
      brightness = 4'd3;
      bad = 0; viol = 0; lit = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         kk = k;
         step(1'b0, 16'h0, 4'h0);
         if (an[1] == 1'b0 || an[3] == 1'b0) bad++;
         if (an != 4'b1111) begin
            lit++;
            if ((kk % 16) > 3) viol++;
         end
      end
      check("blank_never_low", 32'(bad), 32'd0);
      check("pwm_window", 32'(viol), 32'd0);
      check("pwm_some_lit", 32'(lit > 0), 32'd1);
      blank_mask = 4'h0;
      brightness = 4'd15;

      // 6: reset during PEND
      wait_ready(n, ticks);
      step(1'b1, 16'hBEEF, 4'hF);
      idle(5);
      do_reset();
      bad = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step(1'b0, 16'h0, 4'h0);
         if (an != 4'b1111 && (seg != 7'b1000000 || dp != 1'b1)) bad++;
      end
      check("reset_discard", 32'(bad), 32'd0);

      // decode table: every glyph on digit 0
      for (int i = 0; i < 16; i++) begin
         wait_ready(n, ticks);
         step(1'b1, {4{vecs[i].nib}}, vecs[i].nib);
         wait_ready(n, ticks);
         n = 0;
         while (an !== 4'b1110 && n < 40) begin step(1'b0, 16'h0, 4'h0); n++; end
         check($sformatf("decode_%h", vecs[i].nib), 32'(seg), 32'(vecs[i].exp_seg));
      end

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 49) == 0) blank_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) brightness = 4'($urandom_range(0, 15));
         step($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
